// File: rtl/mul_hilo_acc.sv
`default_nettype none
// ============================================================================
// Module   : mul_hilo_acc
// Purpose  : Sequential HI/LO accumulator stage placed after a combinational
//            32x32 signed Booth multiplier. Accepts MULT/MADD/MSUB/MTHI/
//            MTLO/CLR/NOP requests over valid/ready. Registers the
//            multiplier operands, then one cycle later writes,
//            accumulates into, or subtracts from the 64-bit HI:LO pair.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk       in   rising-edge clock
//   reset_n   in   asynchronous active-low reset
//   in_valid  in   request valid
//   in_ready  out  request can be accepted this cycle (IDLE/DONE)
//   op        in   3-bit opcode (000 MULT .. 101 CLR, 11x NOP)
//   src_a     in   operand A, also MTHI/MTLO data
//   src_b     in   operand B
//   mul_a     out  registered multiplicand to the multiplier
//   mul_b     out  registered multiplier to the multiplier
//   mul_p     in   signed 2*XLEN product from the multiplier
//   hi, lo    out  architectural HI/LO registers
//   done      out  one-cycle completion pulse
//   sat       out  sticky saturation flag (0 when saturation compiled out)
// Build option
//   MUL_HILO_SAT_EN : saturate MADD/MSUB on signed 64-bit overflow
// ============================================================================
module mul_hilo_acc #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        op,
    input  logic [XLEN-1:0]   src_a,
    input  logic [XLEN-1:0]   src_b,
    output logic [XLEN-1:0]   mul_a,
    output logic [XLEN-1:0]   mul_b,
    input  logic [2*XLEN-1:0] mul_p,
    output logic [XLEN-1:0]   hi,
    output logic [XLEN-1:0]   lo,
    output logic              done,
    output logic              sat
);

    localparam logic [2:0] OP_MULT = 3'b000;
    localparam logic [2:0] OP_MADD = 3'b001;
    localparam logic [2:0] OP_MSUB = 3'b010;
    localparam logic [2:0] OP_MTHI = 3'b011;
    localparam logic [2:0] OP_MTLO = 3'b100;
    localparam logic [2:0] OP_CLR  = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q;
    logic                in_ready_q;
    logic                done_q;
    logic [2:0]          op_q;
    logic [XLEN-1:0]     mul_a_q;
    logic [XLEN-1:0]     mul_b_q;
    logic [XLEN-1:0]     hi_q;
    logic [XLEN-1:0]     lo_q;
    logic [2*XLEN-1:0]   hilo_d;

    logic [2*XLEN-1:0]   acc_w;
    logic [2*XLEN-1:0]   sum_w;
    logic [2*XLEN-1:0]   dif_w;

    assign acc_w = {hi_q, lo_q};
    assign sum_w = acc_w + mul_p;
    assign dif_w = acc_w - mul_p;

`ifdef MUL_HILO_SAT_EN
    localparam logic [2*XLEN-1:0] SAT_MAX = {1'b0, {(2*XLEN-1){1'b1}}};
    localparam logic [2*XLEN-1:0] SAT_MIN = {1'b1, {(2*XLEN-1){1'b0}}};

    logic sat_q;
    logic sat_d;
    logic add_ovf_w;
    logic sub_ovf_w;

    // Addition overflows when both operands share a sign the result lacks;
    // subtraction when operand signs differ and the result flips from acc.
    assign add_ovf_w = (acc_w[2*XLEN-1] == mul_p[2*XLEN-1]) &&
                       (sum_w[2*XLEN-1] != acc_w[2*XLEN-1]);
    assign sub_ovf_w = (acc_w[2*XLEN-1] != mul_p[2*XLEN-1]) &&
                       (dif_w[2*XLEN-1] != acc_w[2*XLEN-1]);
`endif

    // Next HI:LO value, applied only on the EXEC -> DONE edge.
    always_comb begin
        hilo_d = acc_w;
`ifdef MUL_HILO_SAT_EN
        sat_d  = sat_q;
`endif
        case (op_q)
            OP_MULT: hilo_d = mul_p;
            OP_MADD: begin
`ifdef MUL_HILO_SAT_EN
                if (add_ovf_w) begin
                    // On overflow the true result has the sign of acc.
                    hilo_d = acc_w[2*XLEN-1] ? SAT_MIN : SAT_MAX;
                    sat_d  = 1'b1;
                end else begin
                    hilo_d = sum_w;
                end
`else
                hilo_d = sum_w;
`endif
            end
            OP_MSUB: begin
`ifdef MUL_HILO_SAT_EN
                if (sub_ovf_w) begin
                    hilo_d = acc_w[2*XLEN-1] ? SAT_MIN : SAT_MAX;
                    sat_d  = 1'b1;
                end else begin
                    hilo_d = dif_w;
                end
`else
                hilo_d = dif_w;
`endif
            end
            // mul_a_q holds the captured src_a for the move operations.
            OP_MTHI: hilo_d = {mul_a_q, lo_q};
            OP_MTLO: hilo_d = {hi_q, mul_a_q};
            OP_CLR: begin
                hilo_d = '0;
`ifdef MUL_HILO_SAT_EN
                sat_d  = 1'b0;
`endif
            end
            default: hilo_d = acc_w;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            in_ready_q <= 1'b1;
            done_q     <= 1'b0;
            op_q       <= 3'b000;
            mul_a_q    <= '0;
            mul_b_q    <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
`ifdef MUL_HILO_SAT_EN
            sat_q      <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    // in_ready_q is always 1 here, so valid alone accepts.
                    if (in_valid) begin
                        op_q       <= op;
                        mul_a_q    <= src_a;
                        mul_b_q    <= src_b;
                        state_q    <= S_EXEC;
                        in_ready_q <= 1'b0;
                    end else begin
                        state_q    <= S_IDLE;
                        in_ready_q <= 1'b1;
                    end
                end
                S_EXEC: begin
                    hi_q       <= hilo_d[2*XLEN-1:XLEN];
                    lo_q       <= hilo_d[XLEN-1:0];
`ifdef MUL_HILO_SAT_EN
                    sat_q      <= sat_d;
`endif
                    state_q    <= S_DONE;
                    done_q     <= 1'b1;
                    in_ready_q <= 1'b1;
                end
                default: begin
                    state_q    <= S_IDLE;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready = in_ready_q;
    assign done     = done_q;
    assign mul_a    = mul_a_q;
    assign mul_b    = mul_b_q;
    assign hi       = hi_q;
    assign lo       = lo_q;
`ifdef MUL_HILO_SAT_EN
    assign sat      = sat_q;
`else
    assign sat      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mul_hilo_acc.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_hilo_acc
// Purpose  : Self-checking bench for mul_hilo_acc. Models the external
//            signed multiplier, applies a table of directed requests and
//            a few hand-written multi-cycle sequences.
// Revision : 1.0  initial release
// ============================================================================
module tb_mul_hilo_acc;

`ifdef MUL_HILO_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [63:0] mul_p;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        done;
    logic        sat;

    int errors = 0;
    int checks = 0;

    mul_hilo_acc #(.XLEN(32)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .src_a    (src_a),
        .src_b    (src_b),
        .mul_a    (mul_a),
        .mul_b    (mul_b),
        .mul_p    (mul_p),
        .hi       (hi),
        .lo       (lo),
        .done     (done),
        .sat      (sat)
    );

    // Reference for the combinational Booth multiplier downstream of DUT.
    logic signed [63:0] ext_a;
    logic signed [63:0] ext_b;
    assign ext_a = {{32{mul_a[31]}}, mul_a};
    assign ext_b = {{32{mul_b[31]}}, mul_b};
    assign mul_p = ext_a * ext_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present a request at a negedge and follow it through EXEC and DONE.
    // Returns at the negedge inside the DONE cycle.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        int n;
        op = o; src_a = a; src_b = b; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_accept", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("exec_in_ready", {63'd0, in_ready}, 64'd0);
        chk("exec_done", {63'd0, done}, 64'd0);
        @(negedge clk);
        chk("done_pulse", {63'd0, done}, 64'd1);
        chk("done_in_ready", {63'd0, in_ready}, 64'd1);
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        sat;
    } vec_t;

    vec_t tbl[20];
    int   ntbl;

    int   pulses;
    int   pcyc[4];
    int   idx;
    logic will_accept;
    logic [2:0]  sop[3];
    logic [31:0] sa[3];
    logic [31:0] sb[3];

    initial begin
        // Sequential table: each entry's expectation follows from the ones before.
        tbl[0]  = '{3'b000, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        tbl[1]  = '{3'b000, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0};
        tbl[2]  = '{3'b001, 32'd2,        32'd3,        32'h3FFFFFFF, 32'h00000007, 1'b0};
        tbl[3]  = '{3'b011, 32'h12345678, 32'd0,        32'h12345678, 32'h00000007, 1'b0};
        tbl[4]  = '{3'b100, 32'd0,        32'd0,        32'h12345678, 32'h00000000, 1'b0};
        tbl[5]  = '{3'b010, 32'd1,        32'd1,        32'h12345677, 32'hFFFFFFFF, 1'b0};
        tbl[6]  = '{3'b011, 32'h7FFFFFFF, 32'd0,        32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0};
        tbl[7]  = '{3'b100, 32'hFFFFFFFF, 32'd0,        32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0};
        tbl[8]  = '{3'b001, 32'd1,        32'd1,
                    SAT ? 32'h7FFFFFFF : 32'h80000000, SAT ? 32'hFFFFFFFF : 32'h00000000, SAT};
        tbl[9]  = '{3'b000, 32'd2,        32'd2,        32'h00000000, 32'h00000004, SAT};
        tbl[10] = '{3'b101, 32'd9,        32'd9,        32'h00000000, 32'h00000000, 1'b0};
        tbl[11] = '{3'b011, 32'h80000000, 32'd0,        32'h80000000, 32'h00000000, 1'b0};
        tbl[12] = '{3'b100, 32'd0,        32'd0,        32'h80000000, 32'h00000000, 1'b0};
        tbl[13] = '{3'b010, 32'd1,        32'd1,
                    SAT ? 32'h80000000 : 32'h7FFFFFFF, SAT ? 32'h00000000 : 32'hFFFFFFFF, SAT};
        tbl[14] = '{3'b101, 32'd0,        32'd0,        32'h00000000, 32'h00000000, 1'b0};
        tbl[15] = '{3'b001, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0};
        tbl[16] = '{3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
        tbl[17] = '{3'b110, 32'd5,        32'd5,        32'h00000000, 32'h00000001, 1'b0};
        tbl[18] = '{3'b111, 32'd6,        32'd7,        32'h00000000, 32'h00000001, 1'b0};
        ntbl = 19;

        // Reset with in_valid asserted: request must be ignored.
        reset_n = 1'b0; in_valid = 1'b1; op = 3'b000; src_a = 32'd3; src_b = 32'd3;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        reset_n  = 1'b1;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_hilo", {hi, lo}, 64'd0);
        chk("rst_mul_ab", {mul_a, mul_b}, 64'd0);
        chk("rst_sat", {63'd0, sat}, 64'd0);
        @(negedge clk);
        chk("rst_no_accept", {63'd0, in_ready}, 64'd1);

        for (int i = 0; i < ntbl; i++) begin
            issue(tbl[i].op, tbl[i].a, tbl[i].b);
            chk($sformatf("vec%0d_hi", i), {32'd0, hi}, {32'd0, tbl[i].hi});
            chk($sformatf("vec%0d_lo", i), {32'd0, lo}, {32'd0, tbl[i].lo});
            chk($sformatf("vec%0d_sat", i), {63'd0, sat}, {63'd0, tbl[i].sat});
        end
        @(negedge clk);
        chk("done_single_cycle", {63'd0, done}, 64'd0);

        // Back-to-back MTHI, MTLO, MSUB with in_valid held high throughout.
        sop[0] = 3'b011; sa[0] = 32'h12345678; sb[0] = 32'd0;
        sop[1] = 3'b100; sa[1] = 32'd0;        sb[1] = 32'd0;
        sop[2] = 3'b010; sa[2] = 32'd1;        sb[2] = 32'd1;
        pulses = 0; idx = 0;
        op = sop[0]; src_a = sa[0]; src_b = sb[0]; in_valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            will_accept = in_ready && in_valid;
            @(negedge clk);
            if (done) begin
                if (pulses < 4) pcyc[pulses] = c;
                pulses++;
            end
            if (will_accept) begin
                idx++;
                if (idx < 3) begin
                    op = sop[idx]; src_a = sa[idx]; src_b = sb[idx];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        chk("b2b_pulses", 64'(pulses), 64'd3);
        chk("b2b_first", 64'(pcyc[0]), 64'd1);
        chk("b2b_gap1", 64'(pcyc[1] - pcyc[0]), 64'd2);
        chk("b2b_gap2", 64'(pcyc[2] - pcyc[1]), 64'd2);
        chk("b2b_hilo", {hi, lo}, 64'h12345677_FFFFFFFF);
        chk("b2b_mul_ab_hold", {mul_a, mul_b}, 64'h00000001_00000001);

        // Reset pulsed while MULT 5*5 sits in EXEC.
        op = 3'b000; src_a = 32'd5; src_b = 32'd5; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("mid_exec_ready", {63'd0, in_ready}, 64'd0);
        reset_n = 1'b0;
        #2;
        chk("mid_rst_hilo", {hi, lo}, 64'd0);
        chk("mid_rst_ready", {63'd0, in_ready}, 64'd1);
        chk("mid_rst_done", {63'd0, done}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        chk("mid_rst_no_done", 64'(pulses), 64'd0);
        chk("mid_rst_hilo_after", {hi, lo}, 64'd0);
        chk("mid_rst_sat", {63'd0, sat}, 64'd0);
        issue(3'b000, 32'd2, 32'd2);
        chk("post_rst_mult", {hi, lo}, 64'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
